// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   N_CH independent leaky integrate-and-fire neurons sharing one clock and a
//   global advance enable. Each channel integrates a signed input current with
//   an arithmetic-shift leak and saturating arithmetic. It fires when the
//   integrated sum reaches THRESH and then sits out REFRAC enabled cycles.
//   Per-channel spike counts are accumulated over a T_WINDOW-cycle window and
//   latched at window close.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset, wins over en
//   en            advance enable; all state frozen while low
//   spiking_value packed signed input currents, channel i at [i*W +: W]
//   out_spike     registered one-cycle spike pulse per channel
//   refractory    high while the channel's refractory counter is non-zero
//   spike_cnt     latched window spike counts, channel i at [i*CNT_W +: CNT_W]
//   window_done   one-cycle pulse when spike_cnt updates
module lif_neuron_array #(
  parameter int N_CH       = 4,
  parameter int W          = 16,
  parameter int THRESH     = 256,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 100,
  parameter int T_WINDOW   = 250,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_CH*W-1:0]       spiking_value,
  output logic [N_CH-1:0]         out_spike,
  output logic [N_CH-1:0]         refractory,
  output logic [N_CH*CNT_W-1:0]   spike_cnt,
  output logic                    window_done
);

  localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int WCW = $clog2(T_WINDOW);
  // Two guard bits: potential minus leak plus input can never overflow W+2.
  localparam int SW  = W + 2;

  localparam logic signed [SW-1:0] SAT_MAX  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN  = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [SW-1:0] THRESH_S = SW'(THRESH);
  localparam logic [RW-1:0]        REFRAC_V = RW'(REFRAC);
  localparam logic [WCW-1:0]       WIN_LAST = WCW'(T_WINDOW - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  logic [N_CH-1:0][W-1:0]     in_v;
  logic [N_CH-1:0][W-1:0]     potential;
  logic [N_CH-1:0][RW-1:0]    refr_cnt;
  logic [N_CH-1:0][CNT_W-1:0] acc;
  logic [WCW-1:0]             window_cnt;

  logic [N_CH-1:0][W-1:0]     pot_nxt;
  logic [N_CH-1:0][RW-1:0]    refr_nxt;
  logic [N_CH-1:0][CNT_W-1:0] acc_inc;
  logic [N_CH-1:0]            fire;
  logic signed [SW-1:0]       sum_sat [N_CH];

  assign in_v = spiking_value;

  // Leaky integration of one channel, clamped to the W-bit signed range.
  function automatic logic signed [SW-1:0] leak_sum(input logic [W-1:0] p,
                                                    input logic [W-1:0] x);
    logic signed [SW-1:0] ps;
    logic signed [SW-1:0] lk;
    logic signed [SW-1:0] s;
    ps = $signed({{2{p[W-1]}}, p});
    lk = (LEAK_SHIFT != 0) ? (ps >>> LEAK_SHIFT) : '0;
    s  = ps - lk + $signed({{2{x[W-1]}}, x});
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s;
  endfunction

  // NOTE: every combinational output gets a default before the loop so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pot_nxt  = potential;
    refr_nxt = refr_cnt;
    acc_inc  = acc;
    fire     = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_sat[i] = leak_sum(potential[i], in_v[i]);
      if (refr_cnt[i] != '0) begin
        // Refractory: count down, hold at rest, discard the input.
        refr_nxt[i] = refr_cnt[i] - RW'(1);
        pot_nxt[i]  = '0;
      end else if (sum_sat[i] >= THRESH_S) begin
        fire[i]     = 1'b1;
        pot_nxt[i]  = '0;
        refr_nxt[i] = REFRAC_V;
      end else begin
        pot_nxt[i]  = sum_sat[i][W-1:0];
      end
      // Count includes this edge's fire so a spike on the closing edge lands
      // in the window being closed.
      if (fire[i] && (acc[i] != CNT_MAX)) acc_inc[i] = acc[i] + CNT_W'(1);
    end
  end

  always_comb begin
    refractory = '0;
    for (int i = 0; i < N_CH; i++) refractory[i] = (refr_cnt[i] != '0);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      potential   <= '0;
      refr_cnt    <= '0;
      acc         <= '0;
      window_cnt  <= '0;
      out_spike   <= '0;
      spike_cnt   <= '0;
      window_done <= 1'b0;
    end else begin
      out_spike   <= '0;
      window_done <= 1'b0;
      if (en) begin
        potential <= pot_nxt;
        refr_cnt  <= refr_nxt;
        out_spike <= fire;
        if (window_cnt == WIN_LAST) begin
          window_cnt  <= '0;
          spike_cnt   <= acc_inc;
          acc         <= '0;
          window_done <= 1'b1;
        end else begin
          window_cnt <= window_cnt + WCW'(1);
          acc        <= acc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array
//   Directed bench for lif_neuron_array. dut_a: no leak, REFRAC=3, T_WINDOW=10.
//   dut_b: LEAK_SHIFT=4, REFRAC=3, T_WINDOW=250, 2-bit counters.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] sv_a;
  logic [63:0] sv_b;
  logic [3:0]  spk_a, refr_a, spk_b, refr_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;
  logic        wd_a, wd_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lif_neuron_array #(
    .N_CH(4), .W(16), .THRESH(256), .LEAK_SHIFT(0), .REFRAC(3),
    .T_WINDOW(10), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .spiking_value(sv_a),
    .out_spike(spk_a), .refractory(refr_a), .spike_cnt(cnt_a),
    .window_done(wd_a)
  );

  lif_neuron_array #(
    .N_CH(4), .W(16), .THRESH(256), .LEAK_SHIFT(4), .REFRAC(3),
    .T_WINDOW(250), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .spiking_value(sv_b),
    .out_spike(spk_b), .refractory(refr_b), .spike_cnt(cnt_b),
    .window_done(wd_b)
  );

  // One clock edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b1;
    sv_a = '0;
    sv_b = '0;
    step();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    sv_a = {4{16'd300}};
    sv_b = {4{16'd300}};
    step();
    step();
    n_checks++;
    if ({spk_a, refr_a, wd_a} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got %b expected 0", {spk_a, refr_a, wd_a});
    end
    n_checks++;
    if (cnt_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_a_cnt: got %h expected 0", cnt_a);
    end
    n_checks++;
    if ({spk_b, refr_b, wd_b, cnt_b} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got %b expected 0", {spk_b, refr_b, wd_b, cnt_b});
    end
    n_checks++;
    if ({dut_a.potential, dut_a.window_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_state: potential/window_cnt not cleared");
    end
    rst  = 1'b0;
    sv_a = '0;
    sv_b = '0;
  endtask

  // ch0 = 64 constant: spikes at edges 4, 11, 18, 25.
  task automatic test_integrate();
    int ph;
    logic [15:0] exp_pot;
    logic        exp_spk, exp_refr;
    do_reset();
    sv_a = {16'd0, 16'd0, 16'd0, 16'd64};
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e < 4) begin
        exp_pot  = 16'(64 * e);
        exp_spk  = 1'b0;
        exp_refr = 1'b0;
      end else begin
        ph       = (e - 4) % 7;
        exp_pot  = (ph <= 3) ? 16'd0 : 16'(64 * (ph - 3));
        exp_spk  = (ph == 0);
        exp_refr = (ph <= 2);
      end
      n_checks++;
      if ({spk_a[0], refr_a[0], dut_a.potential[0]} !== {exp_spk, exp_refr, exp_pot}) begin
        n_fail++;
        $display("FAIL integrate edge %0d: got spk=%b refr=%b pot=%0d expected spk=%b refr=%b pot=%0d",
                 e, spk_a[0], refr_a[0], dut_a.potential[0], exp_spk, exp_refr, exp_pot);
      end
      n_checks++;
      if (spk_a[3:1] !== 3'b000) begin
        n_fail++;
        $display("FAIL integrate_idle_ch edge %0d: got %b expected 000", e, spk_a[3:1]);
      end
    end
  endtask

  task automatic test_leak();
    logic [15:0] exp_pot [3];
    exp_pot = '{16'd160, 16'd150, 16'd141};
    do_reset();
    sv_b = {16'd0, 16'd0, 16'd0, 16'd160};
    for (int e = 0; e < 3; e++) begin
      step();
      sv_b = '0;
      n_checks++;
      if ({spk_b[0], dut_b.potential[0]} !== {1'b0, exp_pot[e]}) begin
        n_fail++;
        $display("FAIL leak step %0d: got spk=%b pot=%0d expected spk=0 pot=%0d",
                 e, spk_b[0], dut_b.potential[0], exp_pot[e]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] in_v    [3];
    logic [15:0] exp_pot [3];
    in_v    = '{16'(-20000), 16'(-20000), 16'd100};
    exp_pot = '{16'(-20000), 16'h8000, 16'(-32668)};
    do_reset();
    for (int e = 0; e < 3; e++) begin
      sv_a = {48'd0, in_v[e]};
      step();
      n_checks++;
      if (dut_a.potential[0] !== exp_pot[e]) begin
        n_fail++;
        $display("FAIL saturate step %0d: got %0d expected %0d",
                 e, $signed(dut_a.potential[0]), $signed(exp_pot[e]));
      end
    end
  endtask

  // ch0 = 64 (spikes 4,11,...,60), ch1 = 300 (spikes 1,5,9,...), ch2 = -5.
  task automatic test_window();
    logic [7:0] exp0 [6];
    logic [7:0] exp1 [6];
    exp0 = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    exp1 = '{8'd3, 8'd2, 8'd3, 8'd2, 8'd3, 8'd2};
    do_reset();
    sv_a = {16'd0, 16'(-5), 16'd300, 16'd64};
    for (int e = 1; e <= 60; e++) begin
      step();
      n_checks++;
      if (wd_a !== (e % 10 == 0)) begin
        n_fail++;
        $display("FAIL window_done edge %0d: got %b expected %b", e, wd_a, (e % 10 == 0));
      end
      if (e == 9) begin
        n_checks++;
        if (cnt_a !== 32'd0) begin
          n_fail++;
          $display("FAIL window_precount: got %h expected 0", cnt_a);
        end
      end
      if (e % 10 == 0) begin
        n_checks++;
        if (cnt_a !== {8'd0, 8'd0, exp1[e/10-1], exp0[e/10-1]}) begin
          n_fail++;
          $display("FAIL window_cnt edge %0d: got %h expected %h", e, cnt_a,
                   {8'd0, 8'd0, exp1[e/10-1], exp0[e/10-1]});
        end
      end
    end
    // Edge 60 carried a ch0 spike coincident with window close.
    n_checks++;
    if ({spk_a[0], wd_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL window_closing_spike: got %b expected 11", {spk_a[0], wd_a});
    end
  endtask

  task automatic test_enable();
    int e;
    do_reset();
    sv_a = {48'd0, 16'd64};
    step();
    step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({dut_a.potential[0], dut_a.refr_cnt[0], dut_a.window_cnt, spk_a[0], wd_a} !==
          {16'd128, 2'd0, 4'd2, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL enable_hold cycle %0d: got pot=%0d refr=%0d win=%0d spk=%b expected 128 0 2 0",
                 k, dut_a.potential[0], dut_a.refr_cnt[0], dut_a.window_cnt, spk_a[0]);
      end
    end
    en = 1'b1;
    e  = 3;
    while (e <= 11) begin
      step();
      n_checks++;
      if (spk_a[0] !== (e == 4 || e == 11)) begin
        n_fail++;
        $display("FAIL enable_resume enabled edge %0d: got %b expected %b",
                 e, spk_a[0], (e == 4 || e == 11));
      end
      if (e == 4) begin
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
          step();
          n_checks++;
          if ({spk_a[0], refr_a[0], dut_a.refr_cnt[0]} !== {1'b0, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL enable_refr_hold cycle %0d: got spk=%b refr=%b cnt=%0d expected 0 1 3",
                     k, spk_a[0], refr_a[0], dut_a.refr_cnt[0]);
          end
        end
        en = 1'b1;
      end
      e++;
    end
  endtask

  // ch0 = 300 on dut_b: spikes 1, 5, 9 -> acc=3, then reset mid-refractory.
  task automatic test_reset_mid();
    do_reset();
    sv_b = {48'd0, 16'd300};
    for (int e = 1; e <= 9; e++) step();
    n_checks++;
    if ({dut_b.acc[0], refr_b[0], spk_b[0]} !== {2'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got acc=%0d refr=%b spk=%b expected 3 1 1",
               dut_b.acc[0], refr_b[0], spk_b[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({spk_b, refr_b, wd_b, cnt_b, dut_b.acc[0], dut_b.window_cnt, dut_b.refr_cnt[0]} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: state not zero (spk=%b refr=%b acc=%0d win=%0d)",
               spk_b, refr_b, dut_b.acc[0], dut_b.window_cnt);
    end
    step();
    n_checks++;
    if ({spk_b[0], dut_b.window_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got spk=%b win=%0d expected 1 1",
               spk_b[0], dut_b.window_cnt);
    end
  endtask

  // ch1 = 300 for a full 250-cycle window: 63 spikes saturate a 2-bit count.
  task automatic test_cnt_saturate();
    do_reset();
    sv_b = {32'd0, 16'd300, 16'd0};
    for (int e = 1; e <= 251; e++) begin
      step();
      if (e >= 249) begin
        n_checks++;
        if (wd_b !== (e == 250)) begin
          n_fail++;
          $display("FAIL cnt_sat_done edge %0d: got %b expected %b", e, wd_b, (e == 250));
        end
      end
    end
    n_checks++;
    if (cnt_b !== 8'b0000_1100) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %b expected 00001100", cnt_b);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    sv_a = '0;
    sv_b = '0;
    test_reset();
    test_integrate();
    test_leak();
    test_saturate();
    test_window();
    test_enable();
    test_reset_mid();
    test_cnt_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
